// File: rtl/dds_ctrl.sv
// dds_ctrl: sequencer for one carrier/code DDS in a tracking channel.
// Owns the DDS increment, enable and synchronous clear, gates accumulation
// to the front-end sample strobe, and takes frequency updates from the loop
// over valid/ready, applying them only on sample boundaries while running.
module dds_ctrl #(
    parameter int                         PHASE_INC_WIDTH = 24,
    parameter logic [PHASE_INC_WIDTH-1:0] INIT_INC        = '0,
    parameter int                         COUNT_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       sample_strobe,
    input  logic                       upd_valid,
    input  logic [PHASE_INC_WIDTH-1:0] upd_inc,
    output logic                       upd_ready,
    output logic                       dds_enable,
    output logic [PHASE_INC_WIDTH-1:0] dds_inc,
    output logic                       dds_clear,
    output logic                       running,
    output logic                       inc_applied,
    output logic [COUNT_WIDTH-1:0]     update_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ARM   = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t                     r_state;
    logic [PHASE_INC_WIDTH-1:0] r_inc;
    logic [PHASE_INC_WIDTH-1:0] r_pend;
    logic                       r_pend_vld;
    logic                       r_clear;
    logic                       r_applied;
    logic [COUNT_WIDTH-1:0]     r_count;
    logic                       w_acc;

    // Only one update is buffered; ready drops while one is pending.
    assign upd_ready    = ~r_pend_vld;
    assign w_acc        = upd_valid & ~r_pend_vld;
    assign dds_enable   = (r_state == S_RUN) & sample_strobe;
    assign running      = (r_state == S_RUN);
    assign dds_inc      = r_inc;
    assign dds_clear    = r_clear;
    assign inc_applied  = r_applied;
    assign update_count = r_count;

    // Channel FSM: state, increment, pending buffer, clear and apply strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_inc      <= INIT_INC;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_clear    <= 1'b0;
            r_applied  <= 1'b0;
            r_count    <= '0;
        end else begin
            r_clear   <= 1'b0;
            r_applied <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // Not accumulating, so updates land in dds_inc directly.
                    if (w_acc) r_inc <= upd_inc;
                    if (start && !stop) begin
                        r_state <= S_CLEAR;
                        r_clear <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_count <= '0;
                    if (w_acc) r_inc <= upd_inc;
                    if (stop) begin
                        r_state <= S_IDLE;
                        // A pending update kept across a restart is applied on stop.
                        if (r_pend_vld) begin
                            r_inc      <= r_pend;
                            r_pend_vld <= 1'b0;
                            r_applied  <= 1'b1;
                            r_count    <= {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (w_acc) r_inc <= upd_inc;
                    if (stop) begin
                        r_state <= S_IDLE;
                        if (r_pend_vld) begin
                            r_inc      <= r_pend;
                            r_pend_vld <= 1'b0;
                            r_applied  <= 1'b1;
                            r_count    <= r_count + 1'b1;
                        end
                    end else if (start) begin
                        r_state <= S_CLEAR;
                        r_clear <= 1'b1;
                    end else if (sample_strobe) begin
                        // The arming strobe only aligns the channel; it does not accumulate.
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        if (r_pend_vld) begin
                            r_inc      <= r_pend;
                            r_pend_vld <= 1'b0;
                            r_applied  <= 1'b1;
                            r_count    <= r_count + 1'b1;
                        end else if (w_acc) begin
                            r_inc <= upd_inc;
                        end
                    end else if (start) begin
                        // Phase restart; any pending update waits for the next RUN strobe.
                        r_state <= S_CLEAR;
                        r_clear <= 1'b1;
                        if (w_acc) begin
                            r_pend     <= upd_inc;
                            r_pend_vld <= 1'b1;
                        end
                    end else if (sample_strobe && r_pend_vld) begin
                        // DDS uses the old increment on this edge; the new one follows.
                        r_inc      <= r_pend;
                        r_pend_vld <= 1'b0;
                        r_applied  <= 1'b1;
                        r_count    <= r_count + 1'b1;
                    end else if (w_acc) begin
                        r_pend     <= upd_inc;
                        r_pend_vld <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_ctrl.sv
// Directed testbench for dds_ctrl with hand-computed expected values.
module tb_dds_ctrl;

    localparam int W  = 24;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, stop, sample_strobe, upd_valid;
    logic [W-1:0]  upd_inc;
    logic          upd_ready, dds_enable, dds_clear, running, inc_applied;
    logic [W-1:0]  dds_inc;
    logic [CW-1:0] update_count;

    int n_checks = 0;
    int n_errors = 0;

    dds_ctrl #(
        .PHASE_INC_WIDTH(W),
        .INIT_INC       (24'h000100),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .sample_strobe(sample_strobe),
        .upd_valid    (upd_valid),
        .upd_inc      (upd_inc),
        .upd_ready    (upd_ready),
        .dds_enable   (dds_enable),
        .dds_inc      (dds_inc),
        .dds_clear    (dds_clear),
        .running      (running),
        .inc_applied  (inc_applied),
        .update_count (update_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then examined 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 0; stop = 0; sample_strobe = 0; upd_valid = 0; upd_inc = '0;
        #12;
        chk("rst_inc",     dds_inc, 32'h000100);
        chk("rst_ready",   upd_ready, 1);
        chk("rst_running", running, 0);
        chk("rst_enable",  dds_enable, 0);
        chk("rst_count",   update_count, 0);
        chk("rst_clear",   dds_clear, 0);
        chk("rst_applied", inc_applied, 0);
        step();
        reset = 1'b0;
        step();

        // Start at cycle 0, strobes at cycle 4 and every 3 cycles after.
        start = 1'b1;
        step();                               // cycle 1
        start = 1'b0;
        chk("clr_c1", dds_clear, 1);
        chk("run_c1", running, 0);
        step();                               // cycle 2
        chk("clr_c2", dds_clear, 0);
        step();                               // cycle 3
        chk("clr_c3", dds_clear, 0);
        step();                               // cycle 4
        for (int c = 4; c <= 14; c++) begin
            sample_strobe = (((c - 4) % 3) == 0);
            #1;
            chk($sformatf("en_c%0d", c), dds_enable, (c >= 5) && sample_strobe);
            chk($sformatf("run_c%0d", c), running, c >= 5);
            step();
        end
        sample_strobe = 1'b0;

        // Single update in RUN, strobe two cycles later.
        upd_valid = 1'b1; upd_inc = 24'h012345;     // t
        #1;
        chk("u1_ready_t", upd_ready, 1);
        step();                                     // t+1
        upd_valid = 1'b0;
        chk("u1_ready_t1", upd_ready, 0);
        chk("u1_inc_t1", dds_inc, 32'h000100);
        step();                                     // t+2
        sample_strobe = 1'b1;
        #1;
        chk("u1_ready_t2", upd_ready, 0);
        chk("u1_inc_t2", dds_inc, 32'h000100);
        chk("u1_en_t2", dds_enable, 1);
        step();                                     // t+3
        sample_strobe = 1'b0;
        chk("u1_inc_t3", dds_inc, 32'h012345);
        chk("u1_app_t3", inc_applied, 1);
        chk("u1_cnt_t3", update_count, 1);
        chk("u1_ready_t3", upd_ready, 1);
        step();
        chk("u1_app_t4", inc_applied, 0);

        // Restart from RUN: counter clears, rearm.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rs_clear", dds_clear, 1);
        chk("rs_run", running, 0);
        step();
        chk("rs_cnt", update_count, 0);
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        chk("rs_running", running, 1);

        // Back-to-back updates 0xA then 0xB, strobes four cycles apart.
        upd_valid = 1'b1; upd_inc = 24'h00000A;     // u
        step();                                     // u+1
        upd_inc = 24'h00000B;
        chk("bb_ready_u1", upd_ready, 0);
        step();                                     // u+2
        sample_strobe = 1'b1;
        #1;
        chk("bb_ready_u2", upd_ready, 0);
        step();                                     // u+3
        sample_strobe = 1'b0;
        chk("bb_inc_a", dds_inc, 32'h00000A);
        chk("bb_app_a", inc_applied, 1);
        chk("bb_ready_u3", upd_ready, 1);
        step();                                     // u+4
        upd_valid = 1'b0;
        chk("bb_ready_u4", upd_ready, 0);
        chk("bb_inc_u4", dds_inc, 32'h00000A);
        step();                                     // u+5
        step();                                     // u+6
        sample_strobe = 1'b1;
        step();                                     // u+7
        sample_strobe = 1'b0;
        chk("bb_inc_b", dds_inc, 32'h00000B);
        chk("bb_app_b", inc_applied, 1);
        chk("bb_cnt", update_count, 2);

        // Pending 0x55, then start and stop together: stop wins.
        upd_valid = 1'b1; upd_inc = 24'h000055;
        step();
        upd_valid = 1'b0;
        chk("ss_ready_pend", upd_ready, 0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("ss_running", running, 0);
        chk("ss_clear", dds_clear, 0);
        chk("ss_inc", dds_inc, 32'h000055);
        chk("ss_app", inc_applied, 1);
        chk("ss_cnt", update_count, 3);
        chk("ss_ready", upd_ready, 1);
        step();
        chk("ss_clear2", dds_clear, 0);
        chk("ss_app2", inc_applied, 0);

        // Direct write in IDLE: no applied pulse, counter unchanged.
        upd_valid = 1'b1; upd_inc = 24'h000033;
        step();
        upd_valid = 1'b0;
        chk("id_inc", dds_inc, 32'h000033);
        chk("id_app", inc_applied, 0);
        chk("id_cnt", update_count, 3);

        // Asynchronous reset mid-cycle with an update pending.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        sample_strobe = 1'b1;
        step();
        sample_strobe = 1'b0;
        chk("ar_running", running, 1);
        upd_valid = 1'b1; upd_inc = 24'h000077;
        step();
        upd_valid = 1'b0;
        chk("ar_pend", upd_ready, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_inc", dds_inc, 32'h000100);
        chk("ar_ready", upd_ready, 1);
        chk("ar_running0", running, 0);
        chk("ar_cnt", update_count, 0);
        chk("ar_app", inc_applied, 0);
        step();
        #3;
        reset = 1'b0;
        step();
        chk("ar_inc_after", dds_inc, 32'h000100);
        chk("ar_ready_after", upd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
